// File: rtl/bright_spot_locator_pkg.sv
// Shared widths, FSM encoding and window helper for the bright-spot centroid locator.
package bright_spot_locator_pkg;

   localparam int SUM_W   = 32;
   localparam int CNT_W   = 20;
   localparam int COORD_W = 13;
   localparam int STEP_W  = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCUM   = 3'd1,
      DIV_X   = 3'd2,
      DIV_Y   = 3'd3,
      PUBLISH = 3'd4
   } state_e;

   // Offset is computed one bit wider, so a coordinate left of the origin wraps
   // to a value larger than any window size and drops out here.
   function automatic logic in_span(input logic [COORD_W:0] off, input logic [COORD_W-1:0] size);
      return off < {1'b0, size};
   endfunction

endpackage

// File: rtl/bright_spot_locator_serial_divider.sv
// 32-step restoring divider; done_o is high during the final step and quotient_o
// already reflects that step, so the caller can capture on the same edge.
module serial_divider
   import bright_spot_locator_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [SUM_W-1:0]   dividend_i,
   input  logic [CNT_W-1:0]   divisor_i,
   output logic               done_o,
   output logic [COORD_W-1:0] quotient_o
);

   logic              busy_q, busy_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [SUM_W-1:0]  quo_q, quo_d;
   logic [CNT_W-1:0]  dvs_q, dvs_d;
   logic [CNT_W:0]    rem_sh_s;
   logic              ge_s;

   assign rem_sh_s   = {rem_q, quo_q[SUM_W-1]};
   assign ge_s       = rem_sh_s >= {1'b0, dvs_q};
   assign done_o     = busy_q && (step_q == 5'd31);
   assign quotient_o = {quo_q[COORD_W-2:0], ge_s};

   // Next-state: start has priority over abort, abort over stepping.
   always_comb begin
      busy_d = busy_q;
      step_d = step_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      if (start_i) begin
         busy_d = 1'b1;
         step_d = 5'd0;
         rem_d  = 20'd0;
         quo_d  = dividend_i;
         dvs_d  = divisor_i;
      end else if (abort_i) begin
         busy_d = 1'b0;
         step_d = 5'd0;
      end else if (busy_q) begin
         rem_d  = ge_s ? CNT_W'(rem_sh_s - {1'b0, dvs_q}) : rem_sh_s[CNT_W-1:0];
         quo_d  = {quo_q[SUM_W-2:0], ge_s};
         step_d = step_q + 5'd1;
         busy_d = !done_o;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         step_q <= 5'd0;
         rem_q  <= 20'd0;
         quo_q  <= 32'd0;
         dvs_q  <= 20'd0;
      end else begin
         busy_q <= busy_d;
         step_q <= step_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
      end
   end

endmodule

// File: rtl/bright_spot_locator.sv
// Accumulates coordinates of bright in-window pixels per frame and publishes their
// centroid 66 cycles after frame end via a shared serial divider.
module bright_spot_locator
   import bright_spot_locator_pkg::*;
#(
   parameter logic [9:0]  THRESH    = 10'd900,
   parameter logic [12:0] WIN_X0    = 13'd0,
   parameter logic [12:0] WIN_Y0    = 13'd0,
   parameter logic [12:0] WIN_W     = 13'd640,
   parameter logic [12:0] WIN_H     = 13'd480,
   parameter logic [19:0] MIN_COUNT = 20'd16
) (
   input  logic         iCLK,
   input  logic         iRST_N,
   input  logic [9:0]   iGray,
   input  logic         iDVAL,
   input  logic [12:0]  iXposition,
   input  logic [12:0]  iYposition,
   input  logic         iFrameStart,
   input  logic         iFrameEnd,
   output logic [12:0]  oXresult,
   output logic [12:0]  oYresult,
   output logic         oFinished,
   output logic         oBusy
);

   state_e             state_q, state_d;
   logic [SUM_W-1:0]   sumx_q, sumx_d, sumy_q, sumy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COORD_W-1:0] qx_q, qx_d, qy_q, qy_d;
   logic [COORD_W-1:0] xres_q, xres_d, yres_q, yres_d;
   logic               fin_q, fin_d, busy_q, busy_d;
   logic [COORD_W:0]   dx_s, dy_s;
   logic               hit_s, div_start_s, div_abort_s, div_done_s;
   logic [SUM_W-1:0]   div_dividend_s;
   logic [COORD_W-1:0] div_quo_s;

   assign dx_s  = {1'b0, iXposition} - {1'b0, WIN_X0};
   assign dy_s  = {1'b0, iYposition} - {1'b0, WIN_Y0};
   assign hit_s = iDVAL && (iGray >= THRESH) && in_span(dx_s, WIN_W) && in_span(dy_s, WIN_H)
                  && (cnt_q != {CNT_W{1'b1}});

   serial_divider u_div (
      .clk_i      (iCLK),
      .rst_ni     (iRST_N),
      .start_i    (div_start_s),
      .abort_i    (div_abort_s),
      .dividend_i (div_dividend_s),
      .divisor_i  (cnt_q),
      .done_o     (div_done_s),
      .quotient_o (div_quo_s)
   );

   // FSM next state, accumulators, divider control and published results.
   always_comb begin
      state_d        = state_q;
      sumx_d         = sumx_q;
      sumy_d         = sumy_q;
      cnt_d          = cnt_q;
      qx_d           = qx_q;
      qy_d           = qy_q;
      xres_d         = xres_q;
      yres_d         = yres_q;
      fin_d          = fin_q;
      div_start_s    = 1'b0;
      div_abort_s    = 1'b0;
      div_dividend_s = sumx_q;
      case (state_q)
         IDLE: begin
            if (iFrameStart) begin
               state_d = ACCUM;
               sumx_d  = 32'd0;
               sumy_d  = 32'd0;
               cnt_d   = 20'd0;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (iFrameEnd) begin
               if (cnt_q >= MIN_COUNT) begin
                  state_d     = DIV_X;
                  div_start_s = 1'b1;
               end else begin
                  state_d = IDLE;
                  fin_d   = 1'b0;
               end
            end else if (iFrameStart) begin
               sumx_d = 32'd0;
               sumy_d = 32'd0;
               cnt_d  = 20'd0;
            end else if (hit_s) begin
               sumx_d = sumx_q + SUM_W'(dx_s[COORD_W-1:0]);
               sumy_d = sumy_q + SUM_W'(dy_s[COORD_W-1:0]);
               cnt_d  = cnt_q + 20'd1;
            end else begin
               state_d = ACCUM;
            end
         end
         DIV_X, DIV_Y: begin
            if (iFrameStart) begin
               state_d     = ACCUM;
               div_abort_s = 1'b1;
               sumx_d      = 32'd0;
               sumy_d      = 32'd0;
               cnt_d       = 20'd0;
            end else if (div_done_s) begin
               if (state_q == DIV_X) begin
                  qx_d           = div_quo_s;
                  state_d        = DIV_Y;
                  div_start_s    = 1'b1;
                  div_dividend_s = sumy_q;
               end else begin
                  qy_d    = div_quo_s;
                  state_d = PUBLISH;
               end
            end else begin
               state_d = state_q;
            end
         end
         PUBLISH: begin
            xres_d = qx_q;
            yres_d = qy_q;
            fin_d  = 1'b1;
            if (iFrameStart) begin
               state_d = ACCUM;
               sumx_d  = 32'd0;
               sumy_d  = 32'd0;
               cnt_d   = 20'd0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == DIV_X) || (state_d == DIV_Y);
   end

   // Datapath and output registers.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         sumx_q  <= 32'd0;
         sumy_q  <= 32'd0;
         cnt_q   <= 20'd0;
         qx_q    <= 13'd0;
         qy_q    <= 13'd0;
         xres_q  <= 13'd0;
         yres_q  <= 13'd0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sumx_q  <= sumx_d;
         sumy_q  <= sumy_d;
         cnt_q   <= cnt_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         xres_q  <= xres_d;
         yres_q  <= yres_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
      end
   end

   assign oXresult  = xres_q;
   assign oYresult  = yres_q;
   assign oFinished = fin_q;
   assign oBusy     = busy_q;

endmodule

// File: doc/bright_spot_locator.md
BRIGHT_SPOT_LOCATOR -- requirements
Module: bright_spot_locator

Interface
REQ-001 Parameter THRESH, default 10'd900: a pixel qualifies when iGray >= THRESH.
REQ-002 Parameter WIN_X0, default 13'd0: window left edge, inclusive, in iXposition units.
REQ-003 Parameter WIN_Y0, default 13'd0: window top edge, inclusive.
REQ-004 Parameter WIN_W, default 13'd640: window width; WIN_H, default 13'd480: window height.
REQ-005 Parameter MIN_COUNT, default 20'd16: minimum qualifying pixels for a valid result.
REQ-006 iCLK  in  1  pixel clock; sole clock.
REQ-007 iRST_N  in  1  asynchronous, active-low reset.
REQ-008 iGray  in  10  grayscale pixel value.
REQ-009 iDVAL  in  1  iGray and the positions are valid this cycle.
REQ-010 iXposition / iYposition  in  13 each  current pixel coordinates.
REQ-011 iFrameStart  in  1  one-cycle pulse before the first pixel of a frame.
REQ-012 iFrameEnd  in  1  one-cycle pulse after the last pixel of a frame.
REQ-013 oXresult / oYresult  out  13 each  centroid relative to (WIN_X0, WIN_Y0).
REQ-014 oFinished  out  1  level; oXresult/oYresult hold a valid centroid.
REQ-015 oBusy  out  1  high in states DIV_X and DIV_Y.

Function
REQ-016 FSM states: IDLE, ACCUM, DIV_X, DIV_Y, PUBLISH.
- IDLE->ACCUM on iFrameStart; ACCUM->DIV_X on iFrameEnd; DIV_X->DIV_Y on divider done; DIV_Y->PUBLISH on divider done; PUBLISH->IDLE after 1 cycle.
REQ-017 On entering ACCUM: clear SUMX (32b), SUMY (32b) and CNT (20b) to 0.
REQ-018 In ACCUM, each cycle where all of the following hold: add (iXposition-WIN_X0) to SUMX, add (iYposition-WIN_Y0) to SUMY, increment CNT.
- iDVAL=1; iGray>=THRESH
- WIN_X0<=iXposition<WIN_X0+WIN_W; WIN_Y0<=iYposition<WIN_Y0+WIN_H
REQ-019 CNT saturates at 20'hFFFFF; SUMX and SUMY stop accumulating once CNT saturates.
REQ-020 On iFrameEnd with CNT<MIN_COUNT: skip division, deassert oFinished the next cycle, return to IDLE; oXresult/oYresult keep their previous values.
REQ-021 Division is unsigned, truncating: DIV_X computes SUMX/CNT, DIV_Y computes SUMY/CNT.
- Each division takes exactly 32 cycles.
- Quotient low 13 bits are captured into internal registers.
REQ-022 PUBLISH updates oXresult, oYresult and sets oFinished=1 in the same cycle.
- Latency: 66 cycles from iFrameEnd to oFinished/results update.
REQ-023 oFinished and the results hold stable through following frames until the next PUBLISH or until a REQ-020 failure.
REQ-024 iFrameStart in DIV_X or DIV_Y aborts the division and enters ACCUM with cleared accumulators; outputs are unchanged.
REQ-025 iFrameStart in ACCUM restarts accumulation (clears accumulators).
REQ-026 iFrameStart and iFrameEnd in the same cycle: iFrameEnd wins in ACCUM; iFrameStart wins in all other states.
REQ-027 Pixels arriving outside ACCUM are ignored.

Reset
REQ-028 While iRST_N=0, asynchronously: state=IDLE; SUMX, SUMY, CNT=0; oXresult=0, oYresult=0, oFinished=0, oBusy=0; divider idle.
REQ-029 Reset deasserted mid-frame: remain in IDLE until the next iFrameStart.

Structure
REQ-030 Shared package holds the FSM state encoding, SUM_W=32, CNT_W=20 and COORD_W=13.
REQ-031 One sub-module, serial_divider: 32-bit dividend, 20-bit divisor, start/done handshake, 32-cycle restoring division, synchronous abort input.

Verification
REQ-032 Frame with a 4x4 block of iGray=1000 at x=100..103, y=50..53, all other pixels 0 -> oXresult=101, oYresult=51, oFinished=1 exactly 66 cycles after iFrameEnd.
REQ-033 Frame with only 15 pixels at 1000 after a valid frame -> oFinished falls to 0; oXresult/oYresult unchanged.
REQ-034 Threshold edges: pixels at 899 are excluded and pixels at 900 are counted; 16 pixels at x=640 with WIN_W=640 are excluded -> 0 qualifying pixels, oFinished=0.
REQ-035 iFrameStart injected 10 cycles into DIV_X -> oBusy drops, prior results hold, and the next frame computes a correct new centroid.
REQ-036 iRST_N pulled low during DIV_Y -> all outputs read 0 immediately; after release, no update occurs until iFrameStart is followed by a full frame.
